// File: rtl/oneway_packet_transmitter_pkg.sv
// rtl/oneway_packet_transmitter_pkg.sv - shared constants, tx state enum and packet-count helper
package oneway_packet_transmitter_pkg;

    localparam int MESSAGE_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

    // Number of packets needed to carry msg_w bits in pkt_w-bit slices
    function automatic int calc_npkt(input int msg_w, input int pkt_w);
        return (msg_w + pkt_w - 1) / pkt_w;
    endfunction

endpackage

// File: rtl/oneway_packet_transmitter_if.sv
// rtl/oneway_packet_transmitter_if.sv - datagram load handshake and packet link signals
interface oneway_packet_transmitter_if #(
    parameter int MSG_W = 16,
    parameter int PKT_W = 6
);
    logic             load;
    logic [MSG_W-1:0] datagram_in;
    logic             ready;
    logic [PKT_W-1:0] packet_out;
    logic             packet_parity;
    logic             packet_pulse;
    logic             transmit_ctrl;
    logic             done;

    modport master (
        output load, datagram_in,
        input  ready, packet_out, packet_parity, packet_pulse, transmit_ctrl, done
    );

    modport slave (
        input  load, datagram_in,
        output ready, packet_out, packet_parity, packet_pulse, transmit_ctrl, done
    );
endinterface

// File: rtl/oneway_packet_transmitter_phase_timer.sv
// rtl/oneway_packet_transmitter_phase_timer.sv - loadable down-counter timing pulse and gap phases
module tx_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] count;

    // Load the phase length minus one; count down and rest at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load_en) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);
endmodule

// File: rtl/oneway_packet_transmitter.sv
// rtl/oneway_packet_transmitter.sv - serialises a datagram LSB-first into strobed parity-protected packets
module oneway_packet_transmitter
    import oneway_packet_transmitter_pkg::*;
#(
    parameter int MSG_W        = MESSAGE_SIZE,
    parameter int PKT_W        = 6,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int PARITY_EN    = 1
) (
    input  logic                          clk_send,
    input  logic                          rst,
    oneway_packet_transmitter_if.slave    bus
);
    localparam int NPKT      = calc_npkt(MSG_W, PKT_W);
    localparam int BUF_W     = NPKT * PKT_W;
    localparam int CNT_W     = $clog2(NPKT + 1);
    localparam int PHASE_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int PH_W      = $clog2(PHASE_MAX + 1);

    tx_state_t        state, state_n;
    logic [BUF_W-1:0] shift_buf;
    logic [CNT_W-1:0] pkt_cnt;
    logic             done_q;

    logic             accept;
    logic             advance;
    logic             finish;
    logic             tmr_load;
    logic [PH_W-1:0]  tmr_val;
    logic             tmr_tc;
    logic             last_pkt;

    assign last_pkt = (pkt_cnt == CNT_W'(NPKT - 1));

    tx_phase_timer #(
        .W (PH_W)
    ) u_phase_timer (
        .clk      (clk_send),
        .rst      (rst),
        .load_en  (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // State register
    always_ff @(posedge clk_send or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic plus the datapath strobes for accept/advance/finish
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    accept  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                tmr_load = 1'b1;
                tmr_val  = PH_W'(PULSE_CYCLES - 1);
                state_n  = PULSE;
            end
            PULSE: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = PH_W'(GAP_CYCLES - 1);
                    state_n  = GAP;
                end
            end
            GAP: begin
                if (tmr_tc) begin
                    if (last_pkt) begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        advance = 1'b1;
                        state_n = SETUP;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Shift buffer and packet counter; low PKT_W bits are the packet on the wire
    always_ff @(posedge clk_send or posedge rst) begin
        if (rst) begin
            shift_buf <= '0;
            pkt_cnt   <= '0;
        end else if (accept) begin
            shift_buf <= BUF_W'(bus.datagram_in);
            pkt_cnt   <= '0;
        end else if (advance) begin
            shift_buf <= shift_buf >> PKT_W;
            pkt_cnt   <= pkt_cnt + CNT_W'(1);
        end
    end

    // One-cycle completion pulse in the first idle cycle after the final gap
    always_ff @(posedge clk_send or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
        end
    end

    assign bus.ready         = (state == IDLE);
    assign bus.transmit_ctrl = (state != IDLE);
    assign bus.packet_pulse  = (state == PULSE);
    assign bus.packet_out    = shift_buf[PKT_W-1:0];
    assign bus.packet_parity = (PARITY_EN != 0) ? ^shift_buf[PKT_W-1:0] : 1'b0;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_oneway_packet_transmitter.sv
// tb/tb_oneway_packet_transmitter.sv - randomized directed bench for oneway_packet_transmitter
module tb_oneway_packet_transmitter;
    logic        clk_send = 1'b0;
    logic        rst      = 1'b1;
    logic        load_drv = 1'b0;
    logic [15:0] dg_drv   = '0;
    int          sel      = 0;
    int          vectors  = 0;
    int          miscompares = 0;

    always #5 clk_send = ~clk_send;

    oneway_packet_transmitter_if #(.MSG_W(16), .PKT_W(6)) if_a ();
    oneway_packet_transmitter_if #(.MSG_W(12), .PKT_W(6)) if_b ();
    oneway_packet_transmitter_if #(.MSG_W(4),  .PKT_W(6)) if_c ();

    assign if_a.load = load_drv && (sel == 0);
    assign if_b.load = load_drv && (sel == 1);
    assign if_c.load = load_drv && (sel == 2);
    assign if_a.datagram_in = dg_drv;
    assign if_b.datagram_in = dg_drv[11:0];
    assign if_c.datagram_in = dg_drv[3:0];

    oneway_packet_transmitter #(.MSG_W(16), .PKT_W(6), .PULSE_CYCLES(1), .GAP_CYCLES(1), .PARITY_EN(1))
        dut_a (.clk_send(clk_send), .rst(rst), .bus(if_a));
    oneway_packet_transmitter #(.MSG_W(12), .PKT_W(6), .PULSE_CYCLES(3), .GAP_CYCLES(2), .PARITY_EN(1))
        dut_b (.clk_send(clk_send), .rst(rst), .bus(if_b));
    oneway_packet_transmitter #(.MSG_W(4), .PKT_W(6), .PULSE_CYCLES(1), .GAP_CYCLES(1), .PARITY_EN(1))
        dut_c (.clk_send(clk_send), .rst(rst), .bus(if_c));

    logic [5:0] o_pkt;
    logic       o_par, o_pulse, o_tc, o_rdy, o_done;

    always_comb begin
        o_pkt = if_a.packet_out; o_par = if_a.packet_parity; o_pulse = if_a.packet_pulse;
        o_tc = if_a.transmit_ctrl; o_rdy = if_a.ready; o_done = if_a.done;
        if (sel == 1) begin
            o_pkt = if_b.packet_out; o_par = if_b.packet_parity; o_pulse = if_b.packet_pulse;
            o_tc = if_b.transmit_ctrl; o_rdy = if_b.ready; o_done = if_b.done;
        end else if (sel == 2) begin
            o_pkt = if_c.packet_out; o_par = if_c.packet_parity; o_pulse = if_c.packet_pulse;
            o_tc = if_c.transmit_ctrl; o_rdy = if_c.ready; o_done = if_c.done;
        end
    end

    function automatic int cfg_msg(input int s);
        return (s == 0) ? 16 : (s == 1) ? 12 : 4;
    endfunction
    function automatic int cfg_p(input int s);
        return (s == 1) ? 3 : 1;
    endfunction
    function automatic int cfg_g(input int s);
        return (s == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] pkt, input logic par, input logic pulse,
                           input logic tc, input logic rdy, input logic dn);
        chk({tag, ".pkt"},   16'(o_pkt),   16'(pkt));
        chk({tag, ".par"},   16'(o_par),   16'(par));
        chk({tag, ".pulse"}, 16'(o_pulse), 16'(pulse));
        chk({tag, ".tc"},    16'(o_tc),    16'(tc));
        chk({tag, ".rdy"},   16'(o_rdy),   16'(rdy));
        chk({tag, ".done"},  16'(o_done),  16'(dn));
    endtask

    // Caller has load_drv=1 and dg_drv=d set at a negedge; frame is accepted at the next posedge.
    // The expected waveform is computed from packet index/phase arithmetic over the busy window.
    task automatic frame(input int s, input logic [15:0] d, input bit spam, input bit nxt, input logic [15:0] nd);
        int          mw, p, g, n, per, b, idx, ph;
        logic [31:0] mask;
        logic [15:0] dm;
        logic [5:0]  ep;
        logic        epulse;
        mw   = cfg_msg(s);
        p    = cfg_p(s);
        g    = cfg_g(s);
        mask = (32'h1 << mw) - 32'h1;
        dm   = d & mask[15:0];
        n    = (mw + 5) / 6;
        per  = 1 + p + g;
        b    = n * per;
        @(posedge clk_send);
        for (int k = 0; k <= b; k++) begin
            @(negedge clk_send);
            if (k < b) begin
                idx    = k / per;
                ph     = k % per;
                epulse = (ph >= 1) && (ph <= p);
                ep     = 6'((dm >> (idx * 6)) & 16'h3F);
                chk_all($sformatf("s%0d_%h_k%0d", s, d, k), ep, ^ep, epulse, 1'b1, 1'b0, 1'b0);
                load_drv = spam;
                dg_drv   = 16'($urandom);
            end else begin
                ep = 6'((dm >> ((n - 1) * 6)) & 16'h3F);
                chk_all($sformatf("s%0d_%h_done", s, d), ep, ^ep, 1'b0, 1'b0, 1'b1, 1'b1);
                load_drv = nxt;
                dg_drv   = nd;
            end
        end
    endtask

    task automatic start(input int s, input logic [15:0] d);
        @(negedge clk_send);
        sel      = s;
        load_drv = 1'b1;
        dg_drv   = d;
        frame(s, d, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        logic [15:0] d1, d2;
        repeat (2) @(negedge clk_send);
        rst = 1'b0;

        // Reset/idle state on every configuration
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_send);
            for (int s = 0; s < 3; s++) begin
                sel = s;
                #1;
                chk_all($sformatf("idle_s%0d_c%0d", s, c), 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end

        // Basic 16-bit frame, then random frames
        start(0, 16'hBEEF);
        for (int i = 0; i < 4; i++) start(0, 16'($urandom));

        // load spammed during a frame is ignored; load in done cycle chains a frame
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        @(negedge clk_send);
        sel = 0; load_drv = 1'b1; dg_drv = d1;
        frame(0, d1, 1'b1, 1'b1, d2);
        frame(0, d2, 1'b0, 1'b0, 16'h0);
        @(negedge clk_send);
        chk_all("post_chain_idle", 6'((d2 >> 12) & 16'hF), ^(d2[15:12]), 1'b0, 1'b0, 1'b1, 1'b0);

        // Longer pulse and gap, two packets
        start(1, 16'h0FC0);
        for (int i = 0; i < 3; i++) start(1, 16'($urandom));

        // Asynchronous reset in the pulse of the second packet
        @(negedge clk_send);
        sel = 0; load_drv = 1'b1; dg_drv = 16'($urandom);
        @(posedge clk_send);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk_send);
            load_drv = 1'b0;
        end
        chk("rst_pre_pulse", 16'(o_pulse), 16'h1);
        #1 rst = 1'b1;
        #1 chk_all("rst_async", 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_send);
            chk_all($sformatf("rst_hold_%0d", k), 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_send);
            chk(($sformatf("rst_nodone_%0d", k)), 16'(o_done), 16'h0);
        end
        start(0, 16'h0001);

        // Datagram narrower than a packet
        start(2, 16'h000A);
        for (int i = 0; i < 3; i++) start(2, 16'($urandom));

        @(negedge clk_send);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
